// File: rtl/rs_link_controller.sv
// Loopback sequencer for an RS(15,9) GF(16) encoder/decoder pair with timeout and statistics.
// Optional channel error injection is built when RS_ERR_INJECT_EN is defined.
module rs_link_controller #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [35:0]      msg_in,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [59:0]      err_mask,
  output logic [35:0]      message,
  output logic             encodeMessage,
  input  logic             encoderBusy,
  input  logic [59:0]      encodedMessage,
  output logic [59:0]      recievedWordIn,
  output logic             decodeMessage,
  input  logic             decoderBusy,
  input  logic [35:0]      messageRecieved,
  output logic [35:0]      out_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mismatch,
  output logic             out_timeout,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] SettleC  = CntW'(SETTLE);
  localparam logic [CntW-1:0] TimeoutC = CntW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StEncStart,
    StEncWait,
    StDecStart,
    StDecWait,
    StOut
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_inc;
  logic [59:0]     rx_word;
  logic            settle_done;
  logic            timeout_hit;
  logic            enc_go;
  logic            enc_done;
  logic            dec_go;
  logic            dec_done;
  logic            in_xfer;
  logic            abort;

`ifdef RS_ERR_INJECT_EN
  logic [59:0] mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (state == StIdle && msg_valid && msg_ready) begin
      mask <= err_mask;
    end
  end

  assign rx_word = encodedMessage ^ mask;
`else
  logic unused_err_mask;

  assign unused_err_mask = ^err_mask;
  assign rx_word         = encodedMessage;
`endif

  // Settle and timeout are judged on the count this cycle will reach, not the stored one.
  assign cnt_inc     = cnt + 1'b1;
  assign settle_done = (cnt_inc >= SettleC);
  assign timeout_hit = (cnt_inc == TimeoutC);

  assign enc_go   = (state == StEncStart) && !encoderBusy;
  assign enc_done = (state == StEncWait) && settle_done && !encoderBusy;
  assign dec_go   = (state == StDecStart) && !decoderBusy;
  assign dec_done = (state == StDecWait) && settle_done && !decoderBusy;
  assign in_xfer  = state inside {StEncStart, StEncWait, StDecStart, StDecWait};
  // A codec finishing on the last allowed cycle still wins over the timeout.
  assign abort    = in_xfer && timeout_hit && !(enc_go || enc_done || dec_go || dec_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      cnt            <= '0;
      msg_ready      <= 1'b1;
      message        <= '0;
      encodeMessage  <= 1'b0;
      recievedWordIn <= '0;
      decodeMessage  <= 1'b0;
      out_msg        <= '0;
      out_valid      <= 1'b0;
      out_mismatch   <= 1'b0;
      out_timeout    <= 1'b0;
      frame_cnt      <= '0;
      err_cnt        <= '0;
    end else if (abort) begin
      state        <= StOut;
      cnt          <= '0;
      out_msg      <= '0;
      out_timeout  <= 1'b1;
      out_mismatch <= 1'b0;
      out_valid    <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          cnt <= '0;
          if (msg_valid && msg_ready) begin
            message   <= msg_in;
            msg_ready <= 1'b0;
            state     <= StEncStart;
          end
        end
        StEncStart: begin
          if (enc_go) begin
            encodeMessage <= ~encodeMessage;
            cnt           <= '0;
            state         <= StEncWait;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StEncWait: begin
          if (enc_done) begin
            recievedWordIn <= rx_word;
            cnt            <= '0;
            state          <= StDecStart;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StDecStart: begin
          if (dec_go) begin
            decodeMessage <= ~decodeMessage;
            cnt           <= '0;
            state         <= StDecWait;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StDecWait: begin
          if (dec_done) begin
            out_msg      <= messageRecieved;
            out_mismatch <= (messageRecieved != message);
            out_timeout  <= 1'b0;
            out_valid    <= 1'b1;
            cnt          <= '0;
            state        <= StOut;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StOut: begin
          cnt <= '0;
          if (out_ready) begin
            out_valid <= 1'b0;
            msg_ready <= 1'b1;
            state     <= StIdle;
            if (!(&frame_cnt)) begin
              frame_cnt <= frame_cnt + 1'b1;
            end
            if ((out_mismatch || out_timeout) && !(&err_cnt)) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_link_controller.sv
// Randomized loopback bench for rs_link_controller with a behavioural toggle/busy codec model.
// Expected results come from a transaction-level reference of the link rules.
module tb_rs_link_controller;

  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CntMax  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [35:0]      msg_in = '0;
  logic             msg_valid = 1'b0;
  logic             msg_ready;
  logic [59:0]      err_mask = '0;
  logic [35:0]      message;
  logic             encodeMessage;
  logic             encoderBusy;
  logic [59:0]      encodedMessage = '0;
  logic [59:0]      recievedWordIn;
  logic             decodeMessage;
  logic             decoderBusy;
  logic [35:0]      messageRecieved = '0;
  logic [35:0]      out_msg;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_mismatch;
  logic             out_timeout;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  rs_link_controller #(
    .SETTLE (SETTLE),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .msg_in         (msg_in),
    .msg_valid      (msg_valid),
    .msg_ready      (msg_ready),
    .err_mask       (err_mask),
    .message        (message),
    .encodeMessage  (encodeMessage),
    .encoderBusy    (encoderBusy),
    .encodedMessage (encodedMessage),
    .recievedWordIn (recievedWordIn),
    .decodeMessage  (decodeMessage),
    .decoderBusy    (decoderBusy),
    .messageRecieved(messageRecieved),
    .out_msg        (out_msg),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_mismatch   (out_mismatch),
    .out_timeout    (out_timeout),
    .frame_cnt      (frame_cnt),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in codec: systematic codeword, decoder returns the data part, optionally corrupted.
  function automatic logic [59:0] enc_fn(input logic [35:0] m);
    return {m[23:0] ^ m[35:12], m};
  endfunction

  logic [35:0] corrupt_pat = 36'h0_0000_0001;
  bit          dec_corrupt = 1'b0;

  function automatic logic [35:0] dec_fn(input logic [59:0] w, input bit c);
    return w[35:0] ^ (c ? corrupt_pat : 36'h0);
  endfunction

  int   enc_lat = 0, dec_lat = 0, enc_left = 0, dec_left = 0, enc_tog = 0, dec_tog = 0;
  bit   enc_hold = 1'b0, dec_hold = 1'b0;
  logic enc_prev = 1'b0, dec_prev = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      enc_prev <= encodeMessage;
      dec_prev <= decodeMessage;
      enc_left <= 0;
      dec_left <= 0;
    end else begin
      enc_prev <= encodeMessage;
      dec_prev <= decodeMessage;
      if (encodeMessage != enc_prev) begin
        enc_tog        <= enc_tog + 1;
        encodedMessage <= enc_fn(message);
        enc_left       <= enc_lat;
      end else if (enc_left > 0) begin
        enc_left <= enc_left - 1;
      end
      if (decodeMessage != dec_prev) begin
        dec_tog         <= dec_tog + 1;
        messageRecieved <= dec_fn(recievedWordIn, dec_corrupt);
        dec_left        <= dec_lat;
      end else if (dec_left > 0) begin
        dec_left <= dec_left - 1;
      end
    end
  end

  assign encoderBusy = enc_hold || (enc_left != 0);
  assign decoderBusy = dec_hold || (dec_left != 0);

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state of the link as seen from outside.
  int unsigned exp_frames = 0;
  int unsigned exp_errs   = 0;
  logic [35:0] exp_m      = '0;
  logic [59:0] exp_rw     = '0;
  logic [35:0] exp_out    = '0;
  bit          exp_bad    = 1'b0;
  int unsigned hs_cyc     = 0;

  task automatic send(input logic [35:0] m, input logic [59:0] mk, input int pre);
    int n;
    n = 0;
    @(negedge clk);
    msg_in    = m;
    err_mask  = mk;
    msg_valid = 1'b1;
    enc_hold  = (pre > 0);
    while (!msg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", 64'(n < 200), 64'd1);
    hs_cyc = cyc;
    @(negedge clk);
    msg_valid = 1'b0;
    msg_in    = 36'({$urandom(), $urandom()});
    err_mask  = 60'({$urandom(), $urandom()});
    repeat (pre) @(negedge clk);
    enc_hold = 1'b0;
  endtask

  task automatic wait_out(output int unsigned lat);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_bound", 64'(out_valid), 64'd1);
    lat = cyc - hs_cyc;
  endtask

  task automatic check_result(input string tag, input bit timed_out);
    check({tag, "_out_msg"}, 64'(out_msg), 64'(timed_out ? 36'h0 : exp_out));
    check({tag, "_mismatch"}, 64'(out_mismatch), 64'(timed_out ? 1'b0 : exp_bad));
    check({tag, "_timeout"}, 64'(out_timeout), 64'(timed_out));
    check({tag, "_message"}, 64'(message), 64'(exp_m));
    check({tag, "_msg_ready"}, 64'(msg_ready), 64'd0);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_frames = (exp_frames < CntMax) ? exp_frames + 1 : CntMax;
    if (exp_bad) exp_errs = (exp_errs < CntMax) ? exp_errs + 1 : CntMax;
    check({tag, "_valid_clr"}, 64'(out_valid), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_errs));
    check({tag, "_ready_back"}, 64'(msg_ready), 64'd1);
    check({tag, "_rw_stable"}, 64'(recievedWordIn), 64'(exp_rw));
  endtask

  task automatic predict(input logic [35:0] m, input logic [59:0] mk, input bit c);
    exp_m = m;
`ifdef RS_ERR_INJECT_EN
    exp_rw = enc_fn(m) ^ mk;
`else
    exp_rw = enc_fn(m);
`endif
    exp_out = dec_fn(exp_rw, c);
    exp_bad = (exp_out != m);
  endtask

  task automatic xfer(input string tag, input logic [35:0] m, input logic [59:0] mk,
                      input int el, input int dl, input bit c, input int pre, input int hold);
    int          te, td;
    int unsigned lat;
    enc_lat     = el;
    dec_lat     = dl;
    dec_corrupt = c;
    te          = enc_tog;
    td          = dec_tog;
    predict(m, mk, c);
    send(m, mk, pre);
    wait_out(lat);
    check_result(tag, 1'b0);
    check({tag, "_rw"}, 64'(recievedWordIn), 64'(exp_rw));
    check({tag, "_enc_toggles"}, 64'(enc_tog - te), 64'd1);
    check({tag, "_dec_toggles"}, 64'(dec_tog - td), 64'd1);
    if (el == 0 && dl == 0 && pre == 0) begin
      check({tag, "_latency"}, 64'(lat), 64'(2 * (SETTLE + 1) + 1));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_msg"}, 64'(out_msg), 64'(exp_out));
    end
    consume(tag);
  endtask

  initial begin
    int unsigned lat;
    int          te, td, seen;
    logic [35:0] m;
    logic [59:0] mk;

    repeat (3) @(negedge clk);
    check("rst_msg_ready", 64'(msg_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_toggles", 64'({encodeMessage, decodeMessage}), 64'd0);
    check("rst_counters", 64'({frame_cnt, err_cnt}), 64'd0);
    check("rst_outputs", 64'({out_msg, out_mismatch, out_timeout}), 64'd0);
    rst = 1'b0;

    // Directed vectors: clean word, three symbol errors, four symbol errors.
    xfer("clean", 36'h0000000E0, 60'h0, 0, 0, 1'b0, 0, 0);
    xfer("three_err", 36'h0000000E0, 60'h000000000081100, 0, 0, 1'b0, 0, 0);
    xfer("four_err", 36'h0000000E0, 60'h000000000581100, 0, 0, 1'b1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      m           = 36'({$urandom(), $urandom()});
      mk          = 60'({$urandom(), $urandom()});
      corrupt_pat = 36'({$urandom(), $urandom()}) | 36'h1;
      xfer("rand", m, mk, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Decoder never leaves busy: abort exactly TIMEOUT cycles after decoder start entry.
    enc_lat  = 0;
    dec_lat  = 0;
    dec_hold = 1'b1;
    te       = enc_tog;
    td       = dec_tog;
    predict(36'h123456789, 60'h0, 1'b0);
    send(36'h123456789, 60'h0, 0);
    wait_out(lat);
    exp_bad = 1'b1;
    check_result("timeout", 1'b1);
    check("timeout_latency", 64'(lat), 64'(1 + (SETTLE + 1) + TIMEOUT));
    check("timeout_enc_toggles", 64'(enc_tog - te), 64'd1);
    check("timeout_dec_toggles", 64'(dec_tog - td), 64'd0);
    consume("timeout");
    dec_hold = 1'b0;

    // Result held back while a new message is already offered.
    xfer("pre_hold", 36'hABCDE0123, 60'h0, 1, 2, 1'b0, 0, 0);
    predict(36'h0FEDCBA98, 60'h0, 1'b0);
    enc_lat = 0;
    dec_lat = 0;
    send(36'h0FEDCBA98, 60'h0, 0);
    wait_out(lat);
    @(negedge clk);
    msg_in    = 36'h555555555;
    msg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_ready", 64'(msg_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_out_msg", 64'(out_msg), 64'(exp_out));
      check("stall_message", 64'(message), 64'(exp_m));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    msg_valid = 1'b0;
    exp_frames = (exp_frames < CntMax) ? exp_frames + 1 : CntMax;
    check("stall_exit_ready", 64'(msg_ready), 64'd1);
    check("stall_not_latched", 64'(message), 64'(exp_m));
    check("stall_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    xfer("after_stall", 36'h555555555, 60'h0, 0, 0, 1'b0, 0, 0);

    // Reset while the encoder is still busy.
    enc_lat = 6;
    send(36'h0CAFE0123, 60'h0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(msg_ready), 64'd1);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_counters", 64'({frame_cnt, err_cnt}), 64'd0);
    check("mid_rst_toggles", 64'({encodeMessage, decodeMessage}), 64'd0);
    check("mid_rst_words", 64'(message) | 64'(recievedWordIn), 64'd0);
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    exp_frames = 0;
    exp_errs   = 0;
    seen       = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", 64'(seen), 64'd0);

    for (int i = 0; i < 6; i++) begin
      m = 36'({$urandom(), $urandom()});
      xfer("rand2", m, 60'({$urandom(), $urandom()}), int'($urandom_range(0, 4)),
           int'($urandom_range(0, 4)), ($urandom_range(0, 1) == 0), 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
